// File: rtl/wptr_level_handler.sv
// Write-side pointer/level logic for an async FIFO: binary+Gray write pointers, full, level, almost-full, sticky overflow.
// Accepted writes and read-pointer changes appear after one wclk edge; writes while full are dropped and flagged.
module wptr_level_handler #(
    parameter int PTR_WIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 w_en,
    input  logic [PTR_WIDTH:0]   g_rptr_sync,
    input  logic                 overflow_clr,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 overflow
);

    localparam logic [PTR_WIDTH:0] AFULL_LVL = (PTR_WIDTH+1)'(AFULL_THRESH);

    logic [PTR_WIDTH:0] b_wptr_q, b_wptr_d;
    logic [PTR_WIDTH:0] g_wptr_q, g_wptr_d;
    logic               wfull_q, wfull_d;
    logic               almost_full_q, almost_full_d;
    logic [PTR_WIDTH:0] wlevel_q, wlevel_d;
    logic               overflow_q, overflow_d;

    logic [PTR_WIDTH:0] b_rptr_sync;
    logic [PTR_WIDTH:0] g_rptr_full_pat;
    logic               wr_acc;
    logic               wr_drop;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        b_rptr_sync = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            b_rptr_sync[i] = ^(g_rptr_sync >> i);
        end
    end

    // Writer is a full lap ahead when the top two Gray bits differ and the rest match.
    assign g_rptr_full_pat = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};

    assign full    = wfull_q | ~wrst_n;
    assign wr_acc  = w_en & ~full;
    assign wr_drop = w_en & full;

    always_comb begin
        b_wptr_d      = b_wptr_q + {{PTR_WIDTH{1'b0}}, wr_acc};
        g_wptr_d      = (b_wptr_d >> 1) ^ b_wptr_d;
        wfull_d       = (g_wptr_d == g_rptr_full_pat);
        wlevel_d      = b_wptr_d - b_rptr_sync;
        almost_full_d = (wlevel_d >= AFULL_LVL);
        overflow_d    = overflow_q;
        if (wr_drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr_q      <= '0;
            g_wptr_q      <= '0;
            wfull_q       <= 1'b0;
            almost_full_q <= 1'b0;
            wlevel_q      <= '0;
            overflow_q    <= 1'b0;
        end else begin
            b_wptr_q      <= b_wptr_d;
            g_wptr_q      <= g_wptr_d;
            wfull_q       <= wfull_d;
            almost_full_q <= almost_full_d;
            wlevel_q      <= wlevel_d;
            overflow_q    <= overflow_d;
        end
    end

    assign b_wptr      = b_wptr_q;
    assign g_wptr      = g_wptr_q;
    assign almost_full = almost_full_q;
    assign wlevel      = wlevel_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_wptr_level_handler.sv
// Bench for wptr_level_handler: vector table, hand sequences for reset/wrap, and randomized run against a counter model.
module tb_wptr_level_handler;

    logic       wclk;
    logic       wrst_n;
    logic       w_en;
    logic [3:0] g_rptr_sync;
    logic       overflow_clr;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wlevel;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    wptr_level_handler #(.PTR_WIDTH(3), .AFULL_THRESH(6)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .w_en         (w_en),
        .g_rptr_sync  (g_rptr_sync),
        .overflow_clr (overflow_clr),
        .b_wptr       (b_wptr),
        .g_wptr       (g_wptr),
        .full         (full),
        .almost_full  (almost_full),
        .wlevel       (wlevel),
        .overflow     (overflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic       w_en;
        logic [3:0] g_rptr;
        logic       clr;
        logic [3:0] exp_b;
        logic [3:0] exp_g;
        logic       exp_full;
        logic       exp_af;
        logic [3:0] exp_lvl;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [3:0] to_gray(int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, logic [3:0] eb, logic [3:0] eg, logic ef,
                           logic eaf, logic [3:0] el, logic eo);
        chk({tag, ".b_wptr"}, 32'(b_wptr), 32'(eb));
        chk({tag, ".g_wptr"}, 32'(g_wptr), 32'(eg));
        chk({tag, ".full"}, 32'(full), 32'(ef));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(eaf));
        chk({tag, ".wlevel"}, 32'(wlevel), 32'(el));
        chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        w_en = 1'b0; overflow_clr = 1'b0; g_rptr_sync = 4'b0000;
        wrst_n = 1'b0;
        #3;
        tick();
        wrst_n = 1'b1;
        #1;
    endtask

    initial begin
        int wr;
        int rd;
        bit seen_bwrap;
        bit seen_gwrap;
        bit m_full;
        bit m_ovf;
        int lvl;
        logic [3:0] prev_b;
        logic [3:0] prev_g;

        // Reset state and idle after release
        w_en = 1'b0; overflow_clr = 1'b0; g_rptr_sync = 4'b0000; wrst_n = 1'b0;
        #2;
        chk_all("reset", 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        tick();
        wrst_n = 1'b1;
        #1;
        chk("release.full", 32'(full), 32'(0));
        for (int i = 0; i < 3; i++) tick();
        chk_all("idle3", 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Fill, overflow, overflow clear, read advance
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0};
        vecs[1]  = '{1'b1, 4'b0000, 1'b0, 4'd2, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0};
        vecs[2]  = '{1'b1, 4'b0000, 1'b0, 4'd3, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0};
        vecs[3]  = '{1'b1, 4'b0000, 1'b0, 4'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0};
        vecs[4]  = '{1'b1, 4'b0000, 1'b0, 4'd5, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0};
        vecs[5]  = '{1'b1, 4'b0000, 1'b0, 4'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b0};
        vecs[6]  = '{1'b1, 4'b0000, 1'b0, 4'd7, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0};
        vecs[7]  = '{1'b1, 4'b0000, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
        vecs[8]  = '{1'b1, 4'b0000, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
        vecs[9]  = '{1'b1, 4'b0000, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
        vecs[11] = '{1'b1, 4'b0000, 1'b1, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
        vecs[12] = '{1'b0, 4'b0000, 1'b1, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
        vecs[13] = '{1'b0, 4'b0010, 1'b0, 4'd8, 4'b1100, 1'b0, 1'b0, 4'd5, 1'b0};
        vecs[14] = '{1'b1, 4'b0010, 1'b0, 4'd9, 4'b1101, 1'b0, 1'b1, 4'd6, 1'b0};
        for (int i = 0; i < 15; i++) begin
            w_en = vecs[i].w_en;
            g_rptr_sync = vecs[i].g_rptr;
            overflow_clr = vecs[i].clr;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].exp_b, vecs[i].exp_g, vecs[i].exp_full,
                    vecs[i].exp_af, vecs[i].exp_lvl, vecs[i].exp_ovf);
        end

        // Wrap: reader stays two behind the writer
        do_reset();
        w_en = 1'b1;
        tick();
        tick();
        wr = 2;
        seen_bwrap = 1'b0;
        seen_gwrap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prev_b = b_wptr;
            prev_g = g_wptr;
            g_rptr_sync = to_gray((wr - 1) % 16);
            tick();
            wr++;
            chk("wrap.b_wptr", 32'(b_wptr), 32'(wr % 16));
            chk("wrap.wlevel", 32'(wlevel), 32'(2));
            chk("wrap.full", 32'(full), 32'(0));
            if (prev_b == 4'b1111 && b_wptr == 4'b0000) seen_bwrap = 1'b1;
            if (prev_g == 4'b1000 && g_wptr == 4'b0000) seen_gwrap = 1'b1;
        end
        chk("wrap.bin_seen", 32'(seen_bwrap), 32'(1));
        chk("wrap.gray_seen", 32'(seen_gwrap), 32'(1));

        // Mid-operation reset pulse between edges
        do_reset();
        w_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        w_en = 1'b0;
        chk("midrst.pre_lvl", 32'(wlevel), 32'(5));
        #2 wrst_n = 1'b0;
        #1;
        chk_all("midrst.low", 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        #1 wrst_n = 1'b1;
        #1;
        chk_all("midrst.rel", 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Randomized run against a read/write counter model
        do_reset();
        wr = 0; rd = 0; m_full = 1'b0; m_ovf = 1'b0;
        for (int c = 0; c < 600; c++) begin
            w_en = ($urandom % 4) != 0;
            overflow_clr = ($urandom % 8) == 0;
            if (rd < wr && ($urandom % 3) == 0) rd++;
            g_rptr_sync = to_gray(rd % 16);
            tick();
            if (w_en && m_full) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            if (w_en && !m_full) wr++;
            lvl = wr - rd;
            m_full = (lvl == 8);
            chk_all("rand", 4'(wr % 16), to_gray(wr % 16), m_full, lvl >= 6, 4'(lvl), m_ovf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wptr_level_handler.md
WPTR_LEVEL_HANDLER -- requirements
Module: wptr_level_handler

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 3, address width; FIFO depth = 2^PTR_WIDTH; legal range PTR_WIDTH >= 2.
REQ-002 SHALL have parameter AFULL_THRESH, default 6, almost-full level; legal range 1..2^PTR_WIDTH.
REQ-003 SHALL have port wclk  input  1  write-domain clock; all state updates on the rising edge.
REQ-004 SHALL have port wrst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port w_en  input  1  write request.
REQ-006 SHALL have port g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer, already synchronized into wclk.
REQ-007 SHALL have port overflow_clr  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port b_wptr  output  PTR_WIDTH+1  binary write pointer, registered.
REQ-009 SHALL have port g_wptr  output  PTR_WIDTH+1  Gray write pointer, registered, sent to the read domain.
REQ-010 SHALL have port full  output  1  FIFO full.
REQ-011 SHALL have port almost_full  output  1  registered; level >= AFULL_THRESH.
REQ-012 SHALL have port wlevel  output  PTR_WIDTH+1  registered occupancy, 0..2^PTR_WIDTH.
REQ-013 SHALL have port overflow  output  1  sticky; a write was attempted while full.

Function
REQ-014 SHALL accept a write when w_en=1 and full=0.
REQ-015 SHALL compute b_wptr_next = b_wptr + accepted, modulo 2^(PTR_WIDTH+1).
REQ-016 SHALL compute g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next.
REQ-017 SHALL update both pointers each edge: b_wptr <= b_wptr_next and g_wptr <= g_wptr_next, so g_wptr changes by exactly one bit per accepted write.
REQ-018 SHALL convert g_rptr_sync to binary b_rptr_sync with the MSB-down XOR prefix (Gray-to-binary).
REQ-019 SHALL register wfull <= (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}).
REQ-020 SHALL drive full = wfull OR NOT wrst_n, so full is 1 while reset is asserted.
REQ-021 SHALL register wlevel <= b_wptr_next - b_rptr_sync, modulo 2^(PTR_WIDTH+1).
REQ-022 SHALL register almost_full <= (wlevel_next >= AFULL_THRESH), using an unsigned compare.
REQ-023 SHALL have no latency from an accepted write to its effect: pointers, full, wlevel and almost_full all reflect that write after the same edge.
REQ-024 SHALL apply a g_rptr_sync change to full, wlevel and almost_full at the next edge only; pessimistic full is therefore permitted.
REQ-025 SHALL handle overflow as follows: an edge with w_en=1 and full=1 sets overflow=1, and the pointers hold.
REQ-026 SHALL clear overflow at an edge with overflow_clr=1, unless the set condition of REQ-025 is also true in that cycle, in which case set wins.
REQ-027 SHALL wrap both pointers naturally, with no special case: binary 1111->0000 and Gray 1000->0000 for PTR_WIDTH=3.
REQ-028 SHALL NOT cause any accepted write, or any change of g_rptr_sync, to produce wlevel > 2^PTR_WIDTH when g_rptr_sync is legal.

Reset
REQ-029 SHALL, on wrst_n low, immediately and asynchronously set b_wptr=0, g_wptr=0, wfull=0, almost_full=0, wlevel=0 and overflow=0.
REQ-030 SHALL hold full=1 while wrst_n=0 (per REQ-020).
REQ-031 SHALL, on reset assertion mid-operation, discard all in-progress state with no partial update.
REQ-032 SHALL, after wrst_n rises with g_rptr_sync=0, drive full=0 combinationally; the first accepted write can occur at the first edge.

Verification
REQ-033 SHALL be covered by a reset scenario: wrst_n=0 -> full=1, all other outputs 0; release with g_rptr_sync=0 -> full=0, and w_en=0 for 3 edges leaves all outputs 0.
REQ-034 SHALL be covered by a fill scenario: g_rptr_sync=0, w_en=1 for 8 edges -> almost_full=1 after edge 6 (wlevel=6); after edge 8, b_wptr=1000, g_wptr=1100, wlevel=8, full=1.
REQ-035 SHALL be covered by an overflow scenario: full=1, w_en=1 for 2 edges -> b_wptr stays 1000 and overflow=1; overflow_clr=1 with w_en=0 -> overflow=0 next edge; overflow_clr=1 with w_en=1 while full -> overflow stays 1.
REQ-036 SHALL be covered by a read-advance scenario: while full, g_rptr_sync=0010 (binary 3) -> next edge full=0, wlevel=5, almost_full=0.
REQ-037 SHALL be covered by a wrap scenario: reader tracks writer 2 behind, 20 writes -> b_wptr passes 1111->0000, g_wptr passes 1000->0000, wlevel constant 2, full never 1.
REQ-038 SHALL be covered by a mid-operation reset scenario: wrst_n pulsed low between edges at wlevel=5 -> outputs cleared before the next edge, full=1 during the pulse.
